// File: rtl/acc_bank_pkg.sv
// Shared encodings for the accumulator bank: command opcodes and stream FSM states.
package acc_bank_pkg;

  localparam logic [1:0] OP_ADD   = 2'd0;
  localparam logic [1:0] OP_SUB   = 2'd1;
  localparam logic [1:0] OP_LOAD  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/acc_lane.sv
// One accumulator channel: count register, add/sub/load/clear with wrap or clamp,
// and a sticky overflow flag.
module acc_lane
  import acc_bank_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_count,
  output logic             o_ovf
);

  logic [WIDTH-1:0] r_count;
  logic             r_ovf;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_next_count;
  logic             w_next_ovf;

  // Extra MSB of the sum/difference is the carry/borrow that marks overflow.
  always_comb begin
    w_next_count = r_count;
    w_next_ovf   = r_ovf;
    w_sum        = {1'b0, r_count} + {1'b0, i_data};
    w_diff       = {1'b0, r_count} - {1'b0, i_data};
    case (i_op)
      OP_ADD: begin
        w_next_count = w_sum[WIDTH-1:0];
        if (w_sum[WIDTH]) begin
          w_next_ovf = 1'b1;
          if (SATURATE) w_next_count = {WIDTH{1'b1}};
        end
      end
      OP_SUB: begin
        w_next_count = w_diff[WIDTH-1:0];
        if (w_diff[WIDTH]) begin
          w_next_ovf = 1'b1;
          if (SATURATE) w_next_count = '0;
        end
      end
      OP_LOAD: begin
        w_next_count = i_data;
        w_next_ovf   = 1'b0;
      end
      default: begin
        w_next_count = '0;
        w_next_ovf   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (i_en) begin
      r_count <= w_next_count;
      r_ovf   <= w_next_ovf;
    end
  end

  assign o_count = r_count;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/acc_bank.sv
// Bank of independent accumulators with a snapshot-and-stream readout path.
// A snapshot captures all channels at once; the stream then emits them in order.
module acc_bank
  import acc_bank_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter bit          SATURATE = 1'b0,
  localparam int unsigned CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [CW-1:0]    cmd_ch,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             show,
  output logic             show_busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_ch,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             out_last
);

  localparam logic [CW-1:0] LAST_IDX = CW'(CHANNELS - 1);

  logic [WIDTH-1:0]    w_count [CHANNELS];
  logic [CHANNELS-1:0] w_ovf;
  logic [CHANNELS-1:0] w_lane_en;

  logic [WIDTH-1:0]    r_snap_count [CHANNELS];
  logic [CHANNELS-1:0] r_snap_ovf;

  state_t              r_state;
  state_t              w_next_state;
  logic [CW-1:0]       r_idx;
  logic [CW-1:0]       w_next_idx;
  logic                w_load_snap;

  logic                r_out_valid;
  logic [CW-1:0]       r_out_ch;
  logic [WIDTH-1:0]    r_out_data;
  logic                r_out_ovf;
  logic                r_out_last;
  logic                w_nxt_valid;
  logic [WIDTH-1:0]    w_nxt_data;
  logic                w_nxt_ovf;
  logic                w_nxt_last;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    assign w_lane_en[g] = cmd_valid && (cmd_ch == CW'(g));

    acc_lane #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_lane_en[g]),
      .i_op    (cmd_op),
      .i_data  (cmd_data),
      .o_count (w_count[g]),
      .o_ovf   (w_ovf[g])
    );
  end

  // Next state plus the registered output word it implies. On the snapshot edge the
  // first word comes straight from the live (pre-command) lane 0 value.
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    w_load_snap  = 1'b0;
    w_nxt_data   = '0;
    w_nxt_ovf    = 1'b0;
    case (r_state)
      IDLE: begin
        if (show) begin
          w_load_snap  = 1'b1;
          w_next_state = STREAM;
          w_next_idx   = '0;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (r_idx == LAST_IDX) begin
            w_next_state = IDLE;
            w_next_idx   = '0;
          end else begin
            w_next_idx = r_idx + CW'(1);
          end
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_idx   = '0;
      end
    endcase
    w_nxt_valid = (w_next_state == STREAM);
    w_nxt_last  = w_nxt_valid && (w_next_idx == LAST_IDX);
    if (w_load_snap) begin
      w_nxt_data = w_count[0];
      w_nxt_ovf  = w_ovf[0];
    end else if (w_nxt_valid) begin
      w_nxt_data = r_snap_count[w_next_idx];
      w_nxt_ovf  = r_snap_ovf[w_next_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_idx       <= w_next_idx;
      r_out_valid <= w_nxt_valid;
      r_out_ch    <= w_next_idx;
      r_out_data  <= w_nxt_data;
      r_out_ovf   <= w_nxt_ovf;
      r_out_last  <= w_nxt_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) r_snap_count[i] <= '0;
      r_snap_ovf <= '0;
    end else if (w_load_snap) begin
      for (int i = 0; i < CHANNELS; i++) r_snap_count[i] <= w_count[i];
      r_snap_ovf <= w_ovf;
    end
  end

  assign show_busy = (r_state == STREAM);
  assign out_valid = r_out_valid;
  assign out_ch    = r_out_ch;
  assign out_data  = r_out_data;
  assign out_ovf   = r_out_ovf;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_acc_bank.sv
// Directed bench for acc_bank: a wrapping and a saturating instance share stimulus;
// every count is read back through the snapshot stream.
module tb_acc_bank;

  localparam int unsigned W  = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned CW = 2;

  localparam logic [1:0] ADD = 2'd0, SUB = 2'd1, LOAD = 2'd2, CLR = 2'd3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic [CW-1:0] cmd_ch;
  logic [1:0]    cmd_op;
  logic [W-1:0]  cmd_data;
  logic          show;
  logic          out_ready;

  logic          busy0, v0, ovf0, last0;
  logic [CW-1:0] ch0;
  logic [W-1:0]  d0;
  logic          busy1, v1, ovf1, last1;
  logic [CW-1:0] ch1;
  logic [W-1:0]  d1;

  acc_bank #(.WIDTH(W), .CHANNELS(N), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ch(cmd_ch), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .show(show), .show_busy(busy0), .out_valid(v0),
    .out_ready(out_ready), .out_ch(ch0), .out_data(d0), .out_ovf(ovf0), .out_last(last0)
  );

  acc_bank #(.WIDTH(W), .CHANNELS(N), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ch(cmd_ch), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .show(show), .show_busy(busy1), .out_valid(v1),
    .out_ready(out_ready), .out_ch(ch1), .out_data(d1), .out_ovf(ovf1), .out_last(last1)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] cap_d0 [N];
  logic [W-1:0] cap_d1 [N];
  logic         cap_o0 [N];
  logic         cap_o1 [N];

  typedef struct {
    logic [CW-1:0] ch;
    logic [1:0]    op;
    logic [W-1:0]  data;
    logic [W-1:0]  e_cnt0;
    logic          e_ovf0;
    logic [W-1:0]  e_cnt1;
    logic          e_ovf1;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic cmd(input logic [CW-1:0] ch, input logic [1:0] op, input logic [W-1:0] d);
    cmd_valid = 1'b1;
    cmd_ch    = ch;
    cmd_op    = op;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Full stream with out_ready held high; checks framing, captures payloads.
  task automatic run_stream();
    out_ready = 1'b1;
    show      = 1'b1;
    tick();
    show      = 1'b0;
    for (int k = 0; k < N; k++) begin
      chk("stream_valid", 32'(v0 & v1), 32'd1);
      chk("stream_busy", 32'(busy0 & busy1), 32'd1);
      chk("stream_ch", 32'(ch0), 32'(k));
      chk("stream_last", 32'(last0), 32'(k == N - 1));
      cap_d0[k] = d0;
      cap_o0[k] = ovf0;
      cap_d1[k] = d1;
      cap_o1[k] = ovf1;
      tick();
    end
    chk("stream_end_valid", 32'(v0 | v1), 32'd0);
    chk("stream_end_busy", 32'(busy0 | busy1), 32'd0);
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_ch = '0; cmd_op = '0; cmd_data = '0;
    show = 1'b0; out_ready = 1'b0;

    //               ch    op    data  wrap      sat
    vecs[0]  = '{2'd2, LOAD, 8'd250, 8'd250, 1'b0, 8'd250, 1'b0};
    vecs[1]  = '{2'd2, ADD,  8'd10,  8'd4,   1'b1, 8'd255, 1'b1};
    vecs[2]  = '{2'd2, CLR,  8'd77,  8'd0,   1'b0, 8'd0,   1'b0};
    vecs[3]  = '{2'd0, LOAD, 8'd3,   8'd3,   1'b0, 8'd3,   1'b0};
    vecs[4]  = '{2'd0, SUB,  8'd5,   8'd254, 1'b1, 8'd0,   1'b1};
    vecs[5]  = '{2'd0, LOAD, 8'd250, 8'd250, 1'b0, 8'd250, 1'b0};
    vecs[6]  = '{2'd0, ADD,  8'd10,  8'd4,   1'b1, 8'd255, 1'b1};
    vecs[7]  = '{2'd0, ADD,  8'd2,   8'd6,   1'b1, 8'd255, 1'b1};
    vecs[8]  = '{2'd3, SUB,  8'd1,   8'd255, 1'b1, 8'd0,   1'b1};
    vecs[9]  = '{2'd3, ADD,  8'd1,   8'd0,   1'b1, 8'd1,   1'b1};
    vecs[10] = '{2'd3, LOAD, 8'd128, 8'd128, 1'b0, 8'd128, 1'b0};
    vecs[11] = '{2'd3, SUB,  8'd128, 8'd0,   1'b0, 8'd0,   1'b0};
    vecs[12] = '{2'd1, ADD,  8'd255, 8'd255, 1'b0, 8'd255, 1'b0};
    vecs[13] = '{2'd1, ADD,  8'd0,   8'd255, 1'b0, 8'd255, 1'b0};

    @(negedge clk);
    do_reset();
    chk("reset_valid", 32'(v0), 32'd0);
    chk("reset_busy", 32'(busy0), 32'd0);
    chk("reset_ch", 32'(ch0), 32'd0);
    chk("reset_data", 32'(d0), 32'd0);
    chk("reset_ovf", 32'(ovf0), 32'd0);
    chk("reset_last", 32'(last0), 32'd0);

    // ch1 += 5 three times -> 0,15,0,0
    for (int i = 0; i < 3; i++) cmd(2'd1, ADD, 8'd5);
    run_stream();
    chk("basic_ch0", 32'(cap_d0[0]), 32'd0);
    chk("basic_ch1", 32'(cap_d0[1]), 32'd15);
    chk("basic_ch2", 32'(cap_d0[2]), 32'd0);
    chk("basic_ch3", 32'(cap_d0[3]), 32'd0);
    chk("basic_ovf", 32'({cap_o0[3], cap_o0[2], cap_o0[1], cap_o0[0]}), 32'd0);

    // Table: one command, then read back the target channel on both instances.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      cmd(vecs[i].ch, vecs[i].op, vecs[i].data);
      run_stream();
      chk($sformatf("vec%0d_wrap_cnt", i), 32'(cap_d0[vecs[i].ch]), 32'(vecs[i].e_cnt0));
      chk($sformatf("vec%0d_wrap_ovf", i), 32'(cap_o0[vecs[i].ch]), 32'(vecs[i].e_ovf0));
      chk($sformatf("vec%0d_sat_cnt", i), 32'(cap_d1[vecs[i].ch]), 32'(vecs[i].e_cnt1));
      chk($sformatf("vec%0d_sat_ovf", i), 32'(cap_o1[vecs[i].ch]), 32'(vecs[i].e_ovf1));
    end

    // Show coincident with ADD ch0 7: snapshot holds pre-command value; re-show mid-stream ignored.
    do_reset();
    cmd(2'd0, LOAD, 8'd1);
    out_ready = 1'b1;
    cmd_valid = 1'b1; cmd_ch = 2'd0; cmd_op = ADD; cmd_data = 8'd7;
    show = 1'b1;
    tick();
    cmd_valid = 1'b0;
    show = 1'b0;
    chk("same_cycle_valid", 32'(v0), 32'd1);
    chk("same_cycle_ch", 32'(ch0), 32'd0);
    chk("same_cycle_snap", 32'(d0), 32'd1);
    show = 1'b1;
    tick();
    show = 1'b0;
    chk("reshow_ch", 32'(ch0), 32'd1);
    tick();
    tick();
    chk("reshow_last", 32'(last0), 32'd1);
    tick();
    chk("reshow_ignored", 32'(v0), 32'd0);
    run_stream();
    chk("same_cycle_live", 32'(cap_d0[0]), 32'd8);

    // Backpressure on ch1 for 3 cycles, then reset mid-stream.
    do_reset();
    cmd(2'd1, LOAD, 8'd42);
    cmd(2'd2, LOAD, 8'd9);
    out_ready = 1'b1;
    show = 1'b1;
    tick();
    show = 1'b0;
    chk("bp_ch0", 32'(ch0), 32'd0);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_valid", 32'(v0), 32'd1);
      chk("bp_hold_ch", 32'(ch0), 32'd1);
      chk("bp_hold_data", 32'(d0), 32'd42);
      tick();
    end
    out_ready = 1'b1;
    chk("bp_release_ch", 32'(ch0), 32'd1);
    tick();
    chk("bp_no_skip_ch", 32'(ch0), 32'd2);
    chk("bp_no_skip_data", 32'(d0), 32'd9);
    do_reset();
    chk("midrst_valid", 32'(v0), 32'd0);
    chk("midrst_busy", 32'(busy0), 32'd0);
    chk("midrst_ch", 32'(ch0), 32'd0);
    chk("midrst_data", 32'(d0), 32'd0);
    chk("midrst_last", 32'(last0), 32'd0);
    run_stream();
    for (int k = 0; k < N; k++) chk($sformatf("midrst_cnt%0d", k), 32'(cap_d0[k]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
